// File: rtl/controle_pkg.sv
// Shared types and codes for the polynomial control unit: FSM state
// encoding, datapath mux/ALU select codes and the packed control word.
package controle_pkg;

    // State codes, kept as plain constants so legacy code can reuse them.
    localparam logic [3:0] ST_IDLE_CODE = 4'd0;
    localparam logic [3:0] ST_LOAD_CODE = 4'd1;
    localparam logic [3:0] ST_OP1_CODE  = 4'd2;
    localparam logic [3:0] ST_OP2_CODE  = 4'd3;
    localparam logic [3:0] ST_OP3_CODE  = 4'd4;
    localparam logic [3:0] ST_OP4_CODE  = 4'd5;
    localparam logic [3:0] ST_OP5_CODE  = 4'd6;
    localparam logic [3:0] ST_DONE_CODE = 4'd7;

    typedef enum logic [3:0] {
        ST_IDLE = ST_IDLE_CODE,
        ST_LOAD = ST_LOAD_CODE,
        ST_OP1  = ST_OP1_CODE,
        ST_OP2  = ST_OP2_CODE,
        ST_OP3  = ST_OP3_CODE,
        ST_OP4  = ST_OP4_CODE,
        ST_OP5  = ST_OP5_CODE,
        ST_DONE = ST_DONE_CODE
    } state_t;

    // Evaluation schedules.
    localparam logic MODE_HORNER = 1'b0;
    localparam logic MODE_DIRECT = 1'b1;

    // Constant select (m0).
    localparam logic [1:0] K_ZERO = 2'b00;
    localparam logic [1:0] K_A    = 2'b01;
    localparam logic [1:0] K_B    = 2'b10;
    localparam logic [1:0] K_C    = 2'b11;

    // Operand-1 mux (m1).
    localparam logic [1:0] M1_K = 2'b00;
    localparam logic [1:0] M1_X = 2'b01;
    localparam logic [1:0] M1_S = 2'b10;
    localparam logic [1:0] M1_H = 2'b11;

    // Operand-2 mux (m2).
    localparam logic [1:0] M2_X = 2'b00;
    localparam logic [1:0] M2_K = 2'b01;
    localparam logic [1:0] M2_S = 2'b10;
    localparam logic [1:0] M2_H = 2'b11;

    // ALU operation (h).
    localparam logic H_ADD = 1'b0;
    localparam logic H_MUL = 1'b1;

    // One cycle's worth of datapath control.
    typedef struct packed {
        logic       lx;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       ls;
        logic       lh;
    } ctrl_t;

    localparam ctrl_t CW_NONE = '0;

    // Build a control word field by field.
    function automatic ctrl_t make_cw(
        input logic       lx,
        input logic [1:0] m0,
        input logic [1:0] m1,
        input logic [1:0] m2,
        input logic       h,
        input logic       ls,
        input logic       lh
    );
        ctrl_t cw;
        cw.lx = lx;
        cw.m0 = m0;
        cw.m1 = m1;
        cw.m2 = m2;
        cw.h  = h;
        cw.ls = ls;
        cw.lh = lh;
        return cw;
    endfunction

endpackage

// File: rtl/controle_if.sv
// Handshake and datapath-control bundle between the system/datapath
// (master) and the control unit (slave). start/mode flow into the
// controller; control word, done, busy and the debug state flow out.
// Handshake: start is a level request sampled only while idle; done
// marks a valid Resultado and, in held mode, stays up until start drops.
interface controle_if;
    import controle_pkg::*;

    logic       start;
    logic       mode;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic       done;
    logic       busy;
    state_t     state;

    modport master (
        output start, mode,
        input  lx, m0, m1, m2, h, ls, lh, done, busy, state
    );

    modport slave (
        input  start, mode,
        output lx, m0, m1, m2, h, ls, lh, done, busy, state
    );
endinterface

// File: rtl/controle_rom.sv
// Combinational lookup from (state, latched mode) to the datapath control
// word. IDLE, LOAD-less states and DONE produce an all-zero word apart
// from lx in LOAD.
module controle_rom
    import controle_pkg::*;
(
    input  state_t state,
    input  logic   mode_q,
    output ctrl_t  cw
);

    // Decode the control word for the current schedule step.
    always_comb begin
        cw = CW_NONE;
        case (state)
            ST_LOAD: cw = make_cw(1'b1, K_ZERO, M1_K, M2_X, H_ADD, 1'b0, 1'b0);
            ST_OP1: begin
                if (mode_q == MODE_DIRECT)
                    cw = make_cw(1'b0, K_ZERO, M1_X, M2_X, H_MUL, 1'b0, 1'b1); // H = X*X
                else
                    cw = make_cw(1'b0, K_A,    M1_K, M2_X, H_MUL, 1'b1, 1'b0); // S = A*X
            end
            ST_OP2: begin
                if (mode_q == MODE_DIRECT)
                    cw = make_cw(1'b0, K_A,    M1_K, M2_H, H_MUL, 1'b0, 1'b1); // H = A*H
                else
                    cw = make_cw(1'b0, K_B,    M1_S, M2_K, H_ADD, 1'b1, 1'b0); // S = S+B
            end
            ST_OP3: begin
                if (mode_q == MODE_DIRECT)
                    cw = make_cw(1'b0, K_B,    M1_K, M2_X, H_MUL, 1'b1, 1'b0); // S = B*X
                else
                    cw = make_cw(1'b0, K_ZERO, M1_S, M2_X, H_MUL, 1'b1, 1'b0); // S = S*X
            end
            ST_OP4: begin
                if (mode_q == MODE_DIRECT)
                    cw = make_cw(1'b0, K_ZERO, M1_S, M2_H, H_ADD, 1'b1, 1'b0); // S = S+H
                else
                    cw = make_cw(1'b0, K_C,    M1_S, M2_K, H_ADD, 1'b1, 1'b0); // S = S+C
            end
            ST_OP5: begin
                if (mode_q == MODE_DIRECT)
                    cw = make_cw(1'b0, K_C,    M1_S, M2_K, H_ADD, 1'b1, 1'b0); // S = S+C
            end
            default: cw = CW_NONE;
        endcase
    end

endmodule

// File: rtl/controle.sv
// Moore control unit for the polynomial datapath. Sequences LOAD and the
// OP steps of either the Horner or the direct schedule, then reports
// completion through done. All outputs decode from registered state only.
module controle
    import controle_pkg::*;
#(
    parameter bit DONE_PULSE = 1'b0
) (
    input  logic       ck,
    input  logic       rst,
    controle_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    logic   mode_q;
    ctrl_t  cw;

    // State register and schedule latch; mode is captured with start.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HORNER;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start)
                mode_q <= bus.mode;
        end
    end

    // Next-state: fixed walk through the OP steps; start only seen in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_OP1;
            ST_OP1:  state_d = ST_OP2;
            ST_OP2:  state_d = ST_OP3;
            ST_OP3:  state_d = ST_OP4;
            ST_OP4:  state_d = (mode_q == MODE_DIRECT) ? ST_OP5 : ST_DONE;
            ST_OP5:  state_d = ST_DONE;
            ST_DONE: begin
                if (DONE_PULSE || !bus.start)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    controle_rom u_rom (
        .state  (state_q),
        .mode_q (mode_q),
        .cw     (cw)
    );

    assign bus.lx    = cw.lx;
    assign bus.m0    = cw.m0;
    assign bus.m1    = cw.m1;
    assign bus.m2    = cw.m2;
    assign bus.h     = cw.h;
    assign bus.ls    = cw.ls;
    assign bus.lh    = cw.lh;
    assign bus.done  = (state_q == ST_DONE);
    assign bus.busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.state = state_q;

endmodule

// File: doc/controle.md
# controle

Control unit for the polynomial datapath (operativo): a Moore FSM that sequences the datapath's register loads, operand-mux selects and add/multiply choice to evaluate Resultado = A·X² + B·X + C. It drives every datapath control input and reports completion to the system through a start/done handshake. Two evaluation schedules are supported: Horner form using only S, and direct form using H as a scratch register.

## Interface
- DONE_PULSE, default 0: 0 = done held high until start is low; 1 = done high for exactly one cycle.
- ck  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request an evaluation; sampled only in IDLE.
- mode  in  1  0 = Horner schedule, 1 = direct schedule; latched with start.
- lx  out  1  load datapath Reg_X from X.
- m0  out  2  constant select: 00 zero, 01 A, 10 B, 11 C.
- m1  out  2  operand-1 mux: 00 constant(m0), 01 X, 10 S, 11 H.
- m2  out  2  operand-2 mux: 00 X, 01 constant(m0), 10 S, 11 H.
- h  out  1  0 = add, 1 = multiply.
- ls  out  1  load Reg_S with ALU result (priority over lh).
- lh  out  1  load Reg_H with ALU result.
- done  out  1  evaluation complete; Resultado valid.
- busy  out  1  high in every state except IDLE and DONE.

## Operation
- Reset (rst=0): state IDLE; all outputs 0, including m0/m1/m2 = 00. Output 0 on all selects means operand 1 = zero, and nothing is loaded.
- States: IDLE, LOAD, OP1–OP5, DONE.
  - IDLE: all outputs 0.
  - IDLE → LOAD when start=1. mode is latched into mode_q on the same edge.
  - LOAD: lx=1.
  - LOAD → OP1.
- Horner schedule (mode_q=0), OP1–OP4. Each line lists the control word asserted; everything not listed is 0.
  - OP1: S=A·X. m1=00, m0=01, m2=00, h=1, ls=1.
  - OP2: S=S+B. m1=10, m2=01, m0=10, h=0, ls=1.
  - OP3: S=S·X. m1=10, m2=00, h=1, ls=1.
  - OP4: S=S+C. m1=10, m2=01, m0=11, h=0, ls=1.
  - OP4 → DONE.
- Direct schedule (mode_q=1), OP1–OP5:
  - OP1: H=X·X. m1=01, m2=00, h=1, lh=1.
  - OP2: H=A·H. m1=00, m0=01, m2=11, h=1, lh=1.
  - OP3: S=B·X. m1=00, m0=10, m2=00, h=1, ls=1.
  - OP4: S=S+H. m1=10, m2=11, h=0, ls=1.
  - OP5: S=S+C. m1=10, m2=01, m0=11, h=0, ls=1.
  - OP5 → DONE.
- ls and lh are never both 1 in the same state.
- DONE: done=1, all other outputs 0.
  - DONE_PULSE=0: DONE → IDLE on the first edge with start=0. start held high keeps the FSM in DONE; no re-trigger.
  - DONE_PULSE=1: DONE → IDLE unconditionally after one cycle. If start is still high in IDLE, a new evaluation begins.
- start is ignored in LOAD and OP states. mode changes after latch are ignored.
- rst asserted mid-sequence: immediate return to IDLE, all outputs 0. The partial datapath result is discarded.
- Arithmetic width (16 bit, modulo 2¹⁶) is the datapath's. This block has no data path.

## Timing
- Outputs are decoded from the registered state (Moore). No combinational path from start or mode to any output.
- Each control word is stable for the full cycle. The datapath captures on the rising edge that ends that cycle.
- start high at edge E0: LOAD during cycle 1, OP1 during cycle 2.
  - Horner: done rises in cycle 6, i.e. 6 cycles start-to-done.
  - Direct: done rises in cycle 7.
- busy is high in cycles 1–5 (Horner) or 1–6 (direct).
- Minimum start-to-start period with DONE_PULSE=1: 7 cycles (Horner), 8 cycles (direct).

## Structure
- Package controle_pkg holds:
  - state enum;
  - mode constants MODE_HORNER, MODE_DIRECT;
  - constant codes K_ZERO, K_A, K_B, K_C;
  - m1 codes M1_K, M1_X, M1_S, M1_H;
  - m2 codes M2_X, M2_K, M2_S, M2_H;
  - ALU codes H_ADD, H_MUL;
  - packed control-word struct {lx, m0, m1, m2, h, ls, lh}.
- One natural sub-module: controle_rom, a combinational lookup (state, mode_q) → control word. The FSM itself stays in controle.
- The top-level test bench instantiates controle + operativo together.

## Test plan
- Reset: rst=0 mid-OP2 → all outputs 0 within the same cycle; FSM in IDLE; done=0, busy=0.
- Horner: A=2, B=3, C=4, X=5, mode=0, one-cycle start → control words match OP1–OP4 cycle by cycle; done in cycle 6; Resultado = 69 (0x0045).
- Direct: same operands, mode=1 → lh in cycles 2–3, ls in cycles 4–6; done in cycle 7; Resultado = 69.
- Overflow: A=0x0100, B=0, C=1, X=0x0100, mode=0 → Resultado = 0x0001 (wraps mod 2¹⁶).
- Handshake, DONE_PULSE=0: start held high 20 cycles → done stays high and the FSM stays in DONE. Start low → IDLE next edge. A start pulse during busy → ignored; no second done.
- Handshake, DONE_PULSE=1: start held high → done pulses once every 7 cycles (Horner); mode toggled mid-run → takes effect only at the next start sample.
